// File: rtl/fir_mac_engine.sv
// Serial 32-tap FIR multiply-accumulate engine fed by a combinational coefficient ROM.
// Optional output clamp: define FIR_SATURATE_EN; otherwise the result wraps to 16 bits.
module fir_mac_engine #(
  parameter int TAPS = 32,
  parameter int DW   = 16,
  parameter int ACCW = 37
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  output logic [$clog2(TAPS)-1:0]  coef_addr,
  output logic                     coef_mode,
  input  logic [DW-1:0]            coef_data,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = 2 * DW;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [DW-1:0]          delay_r [TAPS];
  logic [AW-1:0]          wr_ptr_r, newest_ptr_r, k_r, tap_idx_s;
  logic signed [ACCW-1:0] acc_r, prod_ext_s;
  logic signed [DW-1:0]   tap_s, coef_s;
  logic signed [PW-1:0]   prod_s;
  logic                   coef_mode_r, in_ready_r, out_valid_r, accept_s;
  logic [DW-1:0]          out_data_r;

  // Scale the Q1.15-weighted sum back to a DW-bit sample (floor, no rounding).
  function automatic logic [DW-1:0] reduce_acc(input logic signed [ACCW-1:0] acc);
`ifdef FIR_SATURATE_EN
    logic signed [ACCW-1:0] shifted;
    shifted = acc >>> (DW - 1);
    if (shifted > $signed({{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}})) begin
      return {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < $signed({{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}})) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return shifted[DW-1:0];
    end
`else
    return acc[PW-2:DW-1];
`endif
  endfunction

  assign accept_s   = (state_r == IDLE) && in_valid;
  assign tap_idx_s  = newest_ptr_r - k_r;
  assign tap_s      = delay_r[tap_idx_s];
  assign coef_s     = coef_data;
  assign prod_s     = tap_s * coef_s;
  assign prod_ext_s = {{(ACCW-PW){prod_s[PW-1]}}, prod_s};

  assign in_ready  = in_ready_r;
  assign coef_addr = k_r;
  assign coef_mode = coef_mode_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

  // Next-state logic: one accept, TAPS accumulate cycles, one output cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = MAC;
        end else begin
          state_s = IDLE;
        end
      end
      MAC: begin
        if (k_r == PTR_LAST) begin
          state_s = DONE;
        end else begin
          state_s = MAC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, tap counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b1;
      wr_ptr_r     <= {AW{1'b0}};
      newest_ptr_r <= {AW{1'b0}};
      k_r          <= {AW{1'b0}};
      acc_r        <= {ACCW{1'b0}};
      coef_mode_r  <= 1'b0;
      out_data_r   <= {DW{1'b0}};
      out_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            newest_ptr_r <= wr_ptr_r;
            wr_ptr_r     <= wr_ptr_r + PTR_ONE;
            coef_mode_r  <= mode;
            k_r          <= {AW{1'b0}};
            acc_r        <= {ACCW{1'b0}};
          end
        end
        MAC: begin
          // k wraps back to 0 after the last tap, leaving coef_addr at 0 when idle.
          acc_r <= acc_r + prod_ext_s;
          k_r   <= k_r + PTR_ONE;
        end
        DONE: begin
          out_data_r  <= reduce_acc(acc_r);
          out_valid_r <= 1'b1;
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Delay line: cleared by reset, written only on an accepted sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        delay_r[i] <= {DW{1'b0}};
      end
    end else if (accept_s) begin
      delay_r[wr_ptr_r] <= in_data;
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: table-driven impulse vectors plus hand-written
// sequences for handshake timing, mode latching, overflow and reset mid-MAC.
module tb_fir_mac_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [4:0]  coef_addr;
  logic        coef_mode;
  logic [15:0] coef_data;
  logic [15:0] out_data;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  fir_mac_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .coef_addr (coef_addr),
    .coef_mode (coef_mode),
    .coef_data (coef_data),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Bench coefficient ROM: bank 0 starts with 49, bank 1 has +/-20633 at taps 15/16.
  function automatic int h(input logic m, input int k);
    if (!m) begin
      if (k == 0) return 49;
      return k * 97 - 1200;
    end
    if (k == 15) return 20633;
    if (k == 16) return -20633;
    if (k % 2 == 1) return 300 * k;
    return -300 * k;
  endfunction

  always_comb coef_data = 16'(h(coef_mode, int'(coef_addr)));

  // Reference model of the sample history and filter output.
  int hist [32];
  int wp;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) hist[i] = 0;
    wp = 0;
  endfunction

  function automatic logic [15:0] model_push(input int x, input logic m);
    longint acc;
    int newest;
    hist[wp] = x;
    newest = wp;
    wp = (wp + 1) % 32;
    acc = 0;
    for (int k = 0; k < 32; k++) begin
      acc += longint'(hist[(newest - k + 32) % 32]) * longint'(h(m, k));
    end
    acc = acc >>> 15;
`ifdef FIR_SATURATE_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`endif
    return 16'(acc);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send one sample (caller sits at a negedge) and return the filtered result.
  task automatic send(input logic [15:0] x, input logic m, output logic [15:0] y);
    int  n;
    bit  busy_bad;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: in_ready still 0 after %0d cycles", n);
    end
    in_data  = x;
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'h5a5a;
    mode     = ~m;
    busy_bad = 1'b0;
    y        = 16'h0;
    for (int j = 0; j <= 34; j++) begin
      if (j > 0) @(negedge clk);
      if (j < 33 && (in_ready !== 1'b0 || out_valid !== 1'b0)) busy_bad = 1'b1;
      if (j == 10) begin
        chk("coef_addr_mid", 32'(coef_addr), 32'd10);
        chk("coef_mode_latch", 32'(coef_mode), 32'(m));
      end
      if (j == 33) begin
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("in_ready_after_done", 32'(in_ready), 32'd1);
        y = out_data;
      end
      if (j == 34) chk("out_valid_one_cycle", 32'(out_valid), 32'd0);
    end
    chk("busy_window", 32'(busy_bad), 32'd0);
  endtask

  typedef struct {
    logic [15:0] x;
    logic        m;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [64];
  logic [15:0] y;
  logic [15:0] exp_y;

  initial begin
    int hv;
    int acc_cyc [$];
    int ov_cyc [$];
    logic [15:0] expq [$];
    bit prev_ov, dbl_ov, drop, seen_ov;

    // Impulse table: floor(32767*h/32768) is h-1 for h>0 and h for h<=0.
    for (int i = 0; i < 64; i++) begin
      tbl[i].m = (i >= 32);
      tbl[i].x = (i % 32 == 0) ? 16'd32767 : 16'd0;
      hv = h(tbl[i].m, i % 32);
      tbl[i].exp = 16'((hv > 0) ? hv - 1 : hv);
    end

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    mode     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_coef_addr", 32'(coef_addr), 32'd0);
    chk("rst_coef_mode", 32'(coef_mode), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse responses of both banks.
    for (int i = 0; i < 64; i++) begin
      send(tbl[i].x, tbl[i].m, y);
      exp_y = model_push(int'($signed(tbl[i].x)), tbl[i].m);
      chk("impulse", 32'(y), 32'(tbl[i].exp));
    end

    // Overflow: sample i lands on tap 31-i in the final output, matched to its sign.
    for (int i = 0; i < 32; i++) begin
      logic [15:0] xs;
      xs = (h(1'b1, 31 - i) < 0) ? 16'h8001 : 16'h7fff;
      send(xs, 1'b1, y);
      exp_y = model_push(int'($signed(xs)), 1'b1);
      chk("overflow_model", 32'(y), 32'(exp_y));
    end
`ifdef FIR_SATURATE_EN
    chk("overflow_clamp", 32'(y), 32'h7fff);
`endif

    // Continuous in_valid: accepts every 34 clocks, output 34 clocks after accept.
    in_data  = 16'd1000;
    mode     = 1'b0;
    in_valid = 1'b1;
    prev_ov  = 1'b0;
    dbl_ov   = 1'b0;
    drop     = 1'b0;
    for (int c = 0; c < 130; c++) begin
      if (drop) in_valid = 1'b0;
      if (out_valid) begin
        if (prev_ov) dbl_ov = 1'b1;
        ov_cyc.push_back(c);
        if (expq.size() > 0) chk("stream_data", 32'(out_data), 32'(expq.pop_front()));
      end
      prev_ov = out_valid;
      if (in_ready && in_valid) begin
        acc_cyc.push_back(c);
        expq.push_back(model_push(1000, 1'b0));
        if (acc_cyc.size() == 3) drop = 1'b1;
      end
      @(negedge clk);
    end
    chk("stream_accepts", 32'(acc_cyc.size()), 32'd3);
    chk("stream_outputs", 32'(ov_cyc.size()), 32'd3);
    chk("stream_no_double_valid", 32'(dbl_ov), 32'd0);
    if (acc_cyc.size() == 3 && ov_cyc.size() == 3) begin
      chk("accept_period_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd34);
      chk("accept_period_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd34);
      for (int i = 0; i < 3; i++) chk("accept_to_valid", 32'(ov_cyc[i] - acc_cyc[i]), 32'd34);
    end

    // Reset at tap 10 aborts the sample and clears history.
    in_data  = 16'd12345;
    mode     = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_at_tap10", 32'(coef_addr), 32'd10);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_coef_addr", 32'(coef_addr), 32'd0);
    chk("midrst_coef_mode", 32'(coef_mode), 32'd0);
    rst_n   = 1'b1;
    seen_ov = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen_ov = 1'b1;
    end
    chk("midrst_no_valid", 32'(seen_ov), 32'd0);
    model_reset();
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].x, tbl[i].m, y);
      exp_y = model_push(int'($signed(tbl[i].x)), tbl[i].m);
      chk("impulse_after_reset", 32'(y), 32'(tbl[i].exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
